// File: rtl/fir_pkg.sv
// Shared types and constants for the N-bit FIR filter and its recursive inverse.
package fir_pkg;

    localparam int DEF_N      = 32;
    localparam int DEF_DELAYS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // The tap counter has to reach DELAYS itself, not just DELAYS-1
    function automatic int tap_cnt_w(input int delays);
        return $clog2(delays + 1);
    endfunction

endpackage

// File: rtl/sample_history.sv
// Shift register of past reconstructed samples; hist slot i holds x[n-1-i].
module sample_history
    import fir_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DELAYS = DEF_DELAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic [N-1:0]          din,
    output logic [DELAYS*N-1:0]   hist
);

    logic [N-1:0] hist_r [DELAYS];

    // History shift on strobe, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAYS; i++) begin
                hist_r[i] <= {N{1'b0}};
            end
        end else if (shift) begin
            hist_r[0] <= din;
            for (int i = 1; i < DELAYS; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
        end else begin
            for (int i = 0; i < DELAYS; i++) begin
                hist_r[i] <= hist_r[i];
            end
        end
    end

    for (genvar g = 0; g < DELAYS; g++) begin : g_flat
        assign hist[g*N +: N] = hist_r[g];
    end

endmodule

// File: rtl/iir_inverse_n.sv
// Recursive inverse of the monic N-bit FIR: x[n] = y[n] - sum b[k]*x[n-k], mod 2^N.
// Optional macro IIR_INVERSE_TRACE_EN adds a simulation-only print of each (y, x) pair.
module iir_inverse_n
    import fir_pkg::*;
#(
    parameter int DELAYS = DEF_DELAYS,
    parameter int N      = DEF_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [N-1:0]            y_in,
    input  logic                    y_valid,
    output logic                    y_ready,
    input  logic [(DELAYS+1)*N-1:0] b,
    output logic [N-1:0]            x_out,
    output logic                    x_valid
);

    localparam int KW = tap_cnt_w(DELAYS);
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(DELAYS);

    state_t          state_r, state_s;
    logic [KW-1:0]   k_r, k_s;
    logic [N-1:0]    acc_r, acc_s;
    logic [N-1:0]    x_out_s;
    logic            x_valid_s;
    logic            shift_s;

    logic [DELAYS*N-1:0] hist_flat_s;
    logic [N-1:0]        b_tap_s    [DELAYS+1];
    logic [N-1:0]        hist_tap_s [DELAYS];
    logic [KW-1:0]       hist_idx_s;
    logic [2*N-1:0]      prod_s;
    logic [N-1:0]        acc_next_s;

    for (genvar g = 0; g <= DELAYS; g++) begin : g_btap
        assign b_tap_s[g] = b[g*N +: N];
    end
    for (genvar g = 0; g < DELAYS; g++) begin : g_htap
        assign hist_tap_s[g] = hist_flat_s[g*N +: N];
    end

    sample_history #(
        .N      (N),
        .DELAYS (DELAYS)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .shift (shift_s && ena),
        .din   (acc_next_s),
        .hist  (hist_flat_s)
    );

    assign y_ready = (state_r == IDLE) && ena;

    // Single shared multiplier; only the low N bits matter since arithmetic wraps mod 2^N
    always_comb begin
        if (k_r == K_ZERO) begin
            hist_idx_s = K_ZERO;
        end else begin
            hist_idx_s = k_r - K_ONE;
        end
        prod_s     = b_tap_s[k_r] * hist_tap_s[hist_idx_s];
        acc_next_s = acc_r - prod_s[N-1:0];
    end

    // Next-state and datapath update decode
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        acc_s     = acc_r;
        x_out_s   = x_out;
        x_valid_s = x_valid;
        shift_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (y_valid) begin
                    acc_s   = y_in;
                    k_s     = K_ONE;
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                acc_s = acc_next_s;
                if (k_r == K_LAST) begin
                    x_out_s   = acc_next_s;
                    x_valid_s = 1'b1;
                    shift_s   = 1'b1;
                    k_s       = K_ZERO;
                    state_s   = OUT;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            OUT: begin
                x_valid_s = 1'b0;
                state_s   = IDLE;
            end
            default: begin
                state_s   = IDLE;
                k_s       = K_ZERO;
                x_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; ena low freezes everything, including a pending strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= K_ZERO;
            acc_r   <= {N{1'b0}};
            x_out   <= {N{1'b0}};
            x_valid <= 1'b0;
        end else if (ena) begin
            state_r <= state_s;
            k_r     <= k_s;
            acc_r   <= acc_s;
            x_out   <= x_out_s;
            x_valid <= x_valid_s;
        end else begin
            state_r <= state_r;
            k_r     <= k_r;
            acc_r   <= acc_r;
            x_out   <= x_out;
            x_valid <= x_valid;
        end
    end

`ifdef IIR_INVERSE_TRACE_EN
    logic [N-1:0] y_in_latched;
    logic         trace_seen_r;

    task print_io();
        $display("%d,%d", $signed(y_in_latched), $signed(x_out));
    endtask

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_in_latched <= {N{1'b0}};
        end else if (y_ready && y_valid) begin
            y_in_latched <= y_in;
        end else begin
            y_in_latched <= y_in_latched;
        end
    end

    // Print once per strobe, even when ena stretches it
    always @(negedge clk) begin
        if (x_valid && !trace_seen_r) begin
            print_io();
        end
        trace_seen_r <= x_valid;
    end
`endif

endmodule

// File: doc/iir_inverse_n.md
# iir_inverse_n

- Recursive inverse (deconvolution) filter that undoes the team's N-bit FIR filter. It reconstructs the FIR input x from the FIR output y.
- Coefficient bus `b` uses the same packing as the FIR. The b[0] field is ignored and treated as 1 (monic filter).
- Computes x[n] = y[n] − Σ_{k=1..DELAYS} b[k]·x[n−k], all arithmetic mod 2^N. FIR accumulation also wraps at N bits, so inversion is exact, including across overflow.
- Sits downstream of the FIR (or a channel it models), with a valid/ready handshake on input and a valid strobe on output. Uses one time-multiplexed multiplier.

## Interface
Parameters:
- DELAYS, 3: number of feedback taps (must be >= 1).
- N, 32: sample and coefficient width, two's complement.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  global enable; low freezes all state.
- y_in  input  N  signed filtered sample.
- y_valid  input  1  y_in is valid.
- y_ready  output  1  block can accept a sample; equals (state==IDLE) && ena.
- b  input  (DELAYS+1)*N  coefficients; tap k occupies bits [(k+1)*N-1 : k*N]; tap 0 is ignored.
- x_out  output  N  signed reconstructed sample, registered.
- x_valid  output  1  one-cycle strobe marking a new x_out.

## Operation
- Reset values: state=IDLE, k=0, acc=0, all history registers hist[0..DELAYS-1]=0, x_out=0, x_valid=0. y_ready follows ena immediately after reset.
- FSM states:
  - IDLE: on y_valid && y_ready, load acc<=y_in and k<=1, then go to MAC. Otherwise hold.
  - MAC: each cycle, acc <= acc − b[k]·hist[k−1], keeping the low N bits of the 2N-bit product and of the difference (wrap, no saturation). k increments.
    - When k==DELAYS: x_out<=updated acc, x_valid<=1, shift history (hist[0]<=updated acc, hist[i]<=hist[i−1]), go to OUT.
  - OUT: x_valid<=0, go to IDLE.
- hist[k−1] always holds x[n−k].
- b is read live during MAC and must be stable from the acceptance edge through the last MAC edge. Changes outside that window affect only later samples.
- y_valid asserted while busy: no transfer occurs and no sample is dropped. The sender holds y_in until y_ready.
- ena low: state, k, acc, history and x_out all hold. x_valid also holds, so an OUT-cycle strobe stretches until ena returns. y_ready is low.
- Reset mid-operation: the in-flight sample is discarded, history is cleared, and no x_valid pulse is emitted.

## Timing
- Acceptance edge E0. MAC occupies edges E1..E_DELAYS. x_out and x_valid update at E_DELAYS.
- x_valid is high for exactly the cycle between E_DELAYS and E_DELAYS+1 (with ena high).
- Latency from acceptance to output: DELAYS cycles.
- Throughput: one sample per DELAYS+2 cycles. The earliest next acceptance is at edge E_DELAYS+2.
- Critical path: one N×N multiply plus one N-bit subtract per cycle.

## Configuration
- Macro: IIR_INVERSE_TRACE_EN.
- Defined: the module provides task print_io(). It also calls $display("%d,%d", y_in_latched, x_out) at every x_valid pulse, where y_in_latched is the y sample accepted at E0. This is simulation-only code guarded by the macro.
- Not defined: no display or task code is compiled. Synthesized logic is identical in both cases.

## Structure
- Shared package fir_pkg holds:
  - typedef enum {IDLE, MAC, OUT} for the FSM state,
  - the default N and DELAYS constants,
  - a localparam function for the tap counter width, $clog2(DELAYS+1).
- One sub-module, sample_history (parameters N and DELAYS): the shift register with a shift strobe, clear on rst, and a parallel read of hist[0..DELAYS-1].
- The multiplier and accumulator stay in the top module.

## Test plan
- Impulse: DELAYS=3, N=32, b1=2, b2=b3=0; inputs y=1,0,0,0 -> x_out=1,−2,4,−8, each x_valid 3 cycles after its acceptance.
- Round trip: random 32-bit coefficients (b0=1) and 200 random samples through the FIR, then this block -> x_out bit-exact equal to the FIR input sequence, including wrapped values.
- Overflow: b1=−1 (0xFFFFFFFF), y=0x7FFFFFFF then y=1 -> x_out=0x7FFFFFFF, then 0x80000000 (wraps, no saturation).
- Backpressure: y_valid held high continuously -> y_ready pulses once per 5 cycles (DELAYS=3); exactly one sample is accepted per pulse, with none dropped or duplicated.
- ena stall: ena drops for 4 cycles mid-MAC -> x_out value unchanged versus no stall, and x_valid delayed by exactly 4 cycles.
- Reset mid-MAC: rst asserted in the second MAC cycle -> no x_valid pulse and all outputs 0. The next impulse y=1 reproduces the impulse-test sequence from a clean history.
